// File: rtl/arith_unit_seq.sv
// arith_unit_seq
// Registered add / subtract / absolute-value / accumulate unit with signed
// overflow, zero and negative flags and optional saturation. A three-state
// FSM (IDLE -> EXEC -> DONE) accepts one operation at a time through a
// start/done handshake. Every output is driven straight from a register.

module arith_unit_seq #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] factor_a,
  input  logic [WIDTH-1:0] factor_b,
  input  logic             clear_acc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic [WIDTH-1:0] accumulator
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ABS = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  // Signed extremes used as clamp values when saturating.
  localparam logic [WIDTH-1:0] SIGNED_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_r;
  state_t           state_next_s;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             overflow_r;
  logic             zero_r;
  logic             negative_r;
  logic [WIDTH-1:0] acc_r;

  logic [WIDTH:0]   a_ext_s;
  logic [WIDTH:0]   b_ext_s;
  logic [WIDTH:0]   acc_ext_s;
  logic [WIDTH:0]   sum_s;
  logic             ovf_s;
  logic [WIDTH-1:0] final_s;

  // Sign-extend operands to WIDTH+1 bits so the true result always fits.
  assign a_ext_s   = {a_r[WIDTH-1], a_r};
  assign b_ext_s   = {b_r[WIDTH-1], b_r};
  assign acc_ext_s = {acc_r[WIDTH-1], acc_r};

  // State register; an asynchronous reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: start only counts in IDLE, EXEC and DONE last one cycle each.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_DONE;
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  // Capture operands and operation on an accepted start; later input changes are ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_r  <= {WIDTH{1'b0}};
      b_r  <= {WIDTH{1'b0}};
      op_r <= 2'b00;
    end else if ((state_r == ST_IDLE) && start) begin
      a_r  <= factor_a;
      b_r  <= factor_b;
      op_r <= operation;
    end else begin
      a_r  <= a_r;
      b_r  <= b_r;
      op_r <= op_r;
    end
  end

  // Datapath: exact WIDTH+1 result, overflow when the two top bits disagree.
  always_comb begin
    sum_s   = {(WIDTH+1){1'b0}};
    ovf_s   = 1'b0;
    final_s = {WIDTH{1'b0}};
    case (op_r)
      OP_ADD: sum_s = a_ext_s + b_ext_s;
      OP_SUB: sum_s = a_ext_s - b_ext_s;
      OP_ABS: begin
        // Negating the most negative value yields +2^(WIDTH-1), which is
        // the lone overflow case; its wrapped form is a unchanged.
        if (a_r[WIDTH-1]) begin
          sum_s = {(WIDTH+1){1'b0}} - a_ext_s;
        end else begin
          sum_s = a_ext_s;
        end
      end
      OP_ACC: sum_s = a_ext_s + acc_ext_s;
      default: sum_s = a_ext_s;
    endcase
    ovf_s = sum_s[WIDTH] ^ sum_s[WIDTH-1];
    // The extended sign bit tells positive from negative overflow.
    if (ovf_s && (SATURATE == 1'b1)) begin
      if (sum_s[WIDTH]) begin
        final_s = SIGNED_MIN;
      end else begin
        final_s = SIGNED_MAX;
      end
    end else begin
      final_s = sum_s[WIDTH-1:0];
    end
  end

  // Result and flags load in EXEC and otherwise hold; flags follow the final value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_r   <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
      negative_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      result_r   <= final_s;
      overflow_r <= ovf_s;
      zero_r     <= (final_s == {WIDTH{1'b0}});
      negative_r <= final_s[WIDTH-1];
    end else begin
      result_r   <= result_r;
      overflow_r <= overflow_r;
      zero_r     <= zero_r;
      negative_r <= negative_r;
    end
  end

  // Accumulator: takes the accumulate result in EXEC, clears only from IDLE.
  // A clear issued together with start has already zeroed it by EXEC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else if ((state_r == ST_EXEC) && (op_r == OP_ACC)) begin
      acc_r <= final_s;
    end else if ((state_r == ST_IDLE) && clear_acc) begin
      acc_r <= {WIDTH{1'b0}};
    end else begin
      acc_r <= acc_r;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign result      = result_r;
  assign overflow    = overflow_r;
  assign zero        = zero_r;
  assign negative    = negative_r;
  assign accumulator = acc_r;

endmodule
